matmul_stream_sched: RTL and testbench

- Scheduler that sequences one NxN matrix product C = A x B through the AXI-stream `matrixmul` dot-product engine.
- Element by element, it reads row i of A and column j of B from two synchronous block RAMs and streams them as N-beat packets on the engine's A and B inputs.
- It collects each single-beat C result and writes it into the result RAM.
- Used by the JPEG DCT path: A = pixel block or coefficient matrix, B = coefficient matrix transposed or intermediate.

---
 rtl/matmul_stream_sched.sv | 167 ++++++++++++++++
 tb/tb_matmul_stream_sched.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_stream_sched.sv
// Sequences one NxN product C = A x B through a streaming dot-product engine.
// Latency: N+2 cycles per C element with no stalls; done N*N*(N+2) cycles after the first fetch.
// Backpressure: A/B beats stall independently on their own tready; C is awaited indefinitely in WAIT_C.
module matmul_stream_sched #(
    parameter int N      = 8,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_rdata,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_rdata,
    output logic              m_axis_a_tvalid,
    input  logic              m_axis_a_tready,
    output logic              m_axis_a_tlast,
    output logic [DATA_W-1:0] m_axis_a_tdata,
    output logic              m_axis_b_tvalid,
    input  logic              m_axis_b_tready,
    output logic              m_axis_b_tlast,
    output logic [DATA_W-1:0] m_axis_b_tdata,
    input  logic              s_axis_c_tvalid,
    output logic              s_axis_c_tready,
    input  logic              s_axis_c_tlast,
    input  logic [DATA_W-1:0] s_axis_c_tdata,
    output logic              c_we,
    output logic [ADDR_W-1:0] c_waddr,
    output logic [DATA_W-1:0] c_wdata
);

    localparam int                CW     = $clog2(N) + 1;
    localparam logic [CW-1:0]     W_LAST = CW'(N - 1);
    localparam logic [ADDR_W-1:0] W_NA   = ADDR_W'(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_WAIT_C,
        S_FIN
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_i;
    logic [CW-1:0] r_j;
    logic [CW-1:0] r_k;
    logic [CW-1:0] w_k_nxt;
    logic          r_a_taken;
    logic          r_b_taken;
    logic          r_err;
    logic          w_send;
    logic          w_a_hs;
    logic          w_b_hs;
    logic          w_beat_done;
    logic          w_k_last;
    logic          w_j_last;
    logic          w_i_last;
    logic          w_c_hs;

    assign w_send   = (r_state == S_SEND);
    assign w_k_last = (r_k == W_LAST);
    assign w_j_last = (r_j == W_LAST);
    assign w_i_last = (r_i == W_LAST);

    // A channel that already handshook for this beat holds tvalid low until its partner catches up.
    assign m_axis_a_tvalid = w_send && !r_a_taken;
    assign m_axis_b_tvalid = w_send && !r_b_taken;
    assign m_axis_a_tlast  = w_send && w_k_last;
    assign m_axis_b_tlast  = w_send && w_k_last;
    assign m_axis_a_tdata  = a_rdata;
    assign m_axis_b_tdata  = b_rdata;

    assign w_a_hs      = m_axis_a_tvalid && m_axis_a_tready;
    assign w_b_hs      = m_axis_b_tvalid && m_axis_b_tready;
    assign w_beat_done = w_send && (r_a_taken || w_a_hs) && (r_b_taken || w_b_hs);

    // Addresses look ahead to the next beat on completion so the RAM output is ready one cycle later,
    // and hold on the current beat while stalled so the presented data stays stable.
    assign w_k_nxt = w_beat_done ? (w_k_last ? '0 : r_k + CW'(1)) : r_k;
    assign a_addr  = ADDR_W'(r_i) * W_NA + ADDR_W'(w_k_nxt);
    assign b_addr  = ADDR_W'(w_k_nxt) * W_NA + ADDR_W'(r_j);

    assign s_axis_c_tready = (r_state == S_WAIT_C);
    assign w_c_hs          = s_axis_c_tready && s_axis_c_tvalid;
    assign c_we            = w_c_hs;
    assign c_waddr         = ADDR_W'(r_i) * W_NA + ADDR_W'(r_j);
    assign c_wdata         = s_axis_c_tdata;

    assign busy = (r_state == S_FETCH) || (r_state == S_SEND) || (r_state == S_WAIT_C);
    assign done = (r_state == S_FIN);
    assign err  = r_err;

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_FETCH;
            S_FETCH:  w_next = S_SEND;
            S_SEND:   if (w_beat_done && w_k_last) w_next = S_WAIT_C;
            S_WAIT_C: if (w_c_hs) w_next = (w_i_last && w_j_last) ? S_FIN : S_FETCH;
            S_FIN:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Element/beat counters, per-channel taken flags and the sticky framing error.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_i       <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_a_taken <= 1'b0;
            r_b_taken <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_i   <= '0;
                        r_j   <= '0;
                        r_k   <= '0;
                        r_err <= 1'b0;
                    end
                end
                S_SEND: begin
                    if (w_beat_done) begin
                        r_a_taken <= 1'b0;
                        r_b_taken <= 1'b0;
                        r_k       <= w_k_nxt;
                    end else begin
                        r_a_taken <= r_a_taken || w_a_hs;
                        r_b_taken <= r_b_taken || w_b_hs;
                    end
                end
                S_WAIT_C: begin
                    if (w_c_hs) begin
                        if (!s_axis_c_tlast) r_err <= 1'b1;
                        if (w_j_last) begin
                            r_j <= '0;
                            r_i <= w_i_last ? '0 : r_i + CW'(1);
                        end else begin
                            r_j <= r_j + CW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_stream_sched.sv
module tb_matmul_stream_sched;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 6;

    typedef struct {
        int a_pct;
        int b_pct;
        int c_lat;
        int err_elem;
        bit a_ident;
        int exp_cycles;
        bit exp_err;
    } vec_t;

    logic          aclk = 1'b0;
    logic          areset;
    logic          start;
    logic          busy, done, err;
    logic [AW-1:0] a_addr, b_addr, c_waddr;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          m_axis_a_tvalid, m_axis_a_tlast;
    logic          m_axis_a_tready = 1'b0;
    logic [DW-1:0] m_axis_a_tdata;
    logic          m_axis_b_tvalid, m_axis_b_tlast;
    logic          m_axis_b_tready = 1'b0;
    logic [DW-1:0] m_axis_b_tdata;
    logic          s_axis_c_tvalid = 1'b0;
    logic          s_axis_c_tready;
    logic          s_axis_c_tlast = 1'b1;
    logic [DW-1:0] s_axis_c_tdata = '0;
    logic          c_we;
    logic [DW-1:0] c_wdata;

    always #5 aclk = ~aclk;

    matmul_stream_sched #(.N(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .aclk(aclk), .areset(areset), .start(start),
        .busy(busy), .done(done), .err(err),
        .a_addr(a_addr), .a_rdata(a_rdata), .b_addr(b_addr), .b_rdata(b_rdata),
        .m_axis_a_tvalid(m_axis_a_tvalid), .m_axis_a_tready(m_axis_a_tready),
        .m_axis_a_tlast(m_axis_a_tlast), .m_axis_a_tdata(m_axis_a_tdata),
        .m_axis_b_tvalid(m_axis_b_tvalid), .m_axis_b_tready(m_axis_b_tready),
        .m_axis_b_tlast(m_axis_b_tlast), .m_axis_b_tdata(m_axis_b_tdata),
        .s_axis_c_tvalid(s_axis_c_tvalid), .s_axis_c_tready(s_axis_c_tready),
        .s_axis_c_tlast(s_axis_c_tlast), .s_axis_c_tdata(s_axis_c_tdata),
        .c_we(c_we), .c_waddr(c_waddr), .c_wdata(c_wdata)
    );

    // Source RAMs (written by the test, read synchronously) and the reference product.
    logic [DW-1:0] amem [64];
    logic [DW-1:0] bmem [64];
    logic [DW-1:0] refm [16];
    logic [DW-1:0] res  [16];

    always @(posedge aclk) begin
        a_rdata <= amem[a_addr];
        b_rdata <= bmem[b_addr];
    end

    // Test configuration, written only by the stimulus process.
    int a_pct = 100, b_pct = 100, c_lat = 0, err_elem = -1;
    bit manual = 1'b0, man_a = 1'b1, man_b = 1'b1;
    int run_seq = 0;

    // Engine model and monitor state, written only by the monitor process.
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    bit c_busy = 0, c_hs_prev = 0, pa_pend = 0, pb_pend = 0, prev_busy = 0, err_pend = 0;
    int c_delay = 0, c_num = 0, cyc = 0, run_seen = 0;
    int wr_cnt = 0, order_err = 0, data_err = 0, pkt_err = 0, vld_drop = 0;
    int done_cnt = 0, fetch_cyc = -1, done_cyc = -1, err_rise = 0;

    int checks = 0;
    int errors = 0;

    // Engine + monitor: inputs change on the falling edge, and the handshakes that the next rising
    // edge will perform are recorded 1 ns later once the DUT's combinational outputs have settled.
    always @(negedge aclk) begin
        logic [DW-1:0] acc;
        cyc++;
        if (c_hs_prev) begin
            s_axis_c_tvalid = 1'b0;
            c_busy          = 1'b0;
            c_hs_prev       = 1'b0;
        end
        m_axis_a_tready = manual ? man_a : ($urandom_range(0, 99) < a_pct);
        m_axis_b_tready = manual ? man_b : ($urandom_range(0, 99) < b_pct);
        if (!c_busy && qa.size() >= N && qb.size() >= N) begin
            acc = '0;
            for (int k = 0; k < N; k++) acc += qa[k] * qb[k];
            for (int k = 0; k < N; k++) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
            end
            s_axis_c_tdata = acc;
            s_axis_c_tlast = (c_num != err_elem);
            c_num++;
            c_busy  = 1'b1;
            c_delay = c_lat;
            if (c_lat == 0) s_axis_c_tvalid = 1'b1;
        end else if (c_busy && !s_axis_c_tvalid) begin
            c_delay--;
            if (c_delay == 0) s_axis_c_tvalid = 1'b1;
        end
        #1;
        if (run_seq != run_seen) begin
            run_seen = run_seq;
            wr_cnt = 0; order_err = 0; data_err = 0; pkt_err = 0; vld_drop = 0;
            done_cnt = 0; fetch_cyc = -1; done_cyc = -1; err_rise = 0; c_num = 0;
        end
        if (areset) begin
            qa.delete();
            qb.delete();
            c_busy = 0; c_hs_prev = 0; s_axis_c_tvalid = 1'b0;
            pa_pend = 0; pb_pend = 0; prev_busy = 0; err_pend = 0;
        end else begin
            if (err_pend && err === 1'b1) err_rise++;
            err_pend = 0;
            if (pa_pend && m_axis_a_tvalid !== 1'b1) vld_drop++;
            if (pb_pend && m_axis_b_tvalid !== 1'b1) vld_drop++;
            pa_pend = m_axis_a_tvalid && !m_axis_a_tready;
            pb_pend = m_axis_b_tvalid && !m_axis_b_tready;
            if (m_axis_a_tvalid && m_axis_a_tready) begin
                if (m_axis_a_tlast !== (qa.size() == N - 1)) pkt_err++;
                qa.push_back(m_axis_a_tdata);
            end
            if (m_axis_b_tvalid && m_axis_b_tready) begin
                if (m_axis_b_tlast !== (qb.size() == N - 1)) pkt_err++;
                qb.push_back(m_axis_b_tdata);
            end
            if (s_axis_c_tvalid && s_axis_c_tready) begin
                c_hs_prev = 1'b1;
                err_pend  = !s_axis_c_tlast && (err === 1'b0);
            end
            if (c_we === 1'b1) begin
                if (int'(c_waddr) != wr_cnt) order_err++;
                if (c_waddr < 16) begin
                    if (c_wdata !== refm[c_waddr]) data_err++;
                    res[c_waddr] = c_wdata;
                end
                wr_cnt++;
            end
            if (busy && !prev_busy && fetch_cyc < 0) fetch_cyc = cyc;
            prev_busy = busy;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_c_we"}, 32'(c_we), 0);
        chk({tag, "_a_tvalid"}, 32'(m_axis_a_tvalid), 0);
        chk({tag, "_b_tvalid"}, 32'(m_axis_b_tvalid), 0);
        chk({tag, "_a_tlast"}, 32'(m_axis_a_tlast), 0);
        chk({tag, "_b_tlast"}, 32'(m_axis_b_tlast), 0);
        chk({tag, "_c_tready"}, 32'(s_axis_c_tready), 0);
        chk({tag, "_a_addr"}, 32'(a_addr), 0);
        chk({tag, "_b_addr"}, 32'(b_addr), 0);
    endtask

    // Load matrices, compute the reference product, start a block and land in its FETCH cycle.
    task automatic begin_block(input vec_t v);
        logic [DW-1:0] acc;
        a_pct = v.a_pct; b_pct = v.b_pct; c_lat = v.c_lat; err_elem = v.err_elem;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                amem[r*N+c] = v.a_ident ? DW'(r == c) : DW'(3*r + c + 1);
                bmem[r*N+c] = DW'(16*r + c);
            end
        end
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                acc = '0;
                for (int k = 0; k < N; k++) acc += amem[r*N+k] * bmem[k*N+c];
                refm[r*N+c] = acc;
            end
        end
        run_seq++;
        @(negedge aclk);
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        #2;
        chk("busy_after_start", 32'(busy), 1);
        chk("err_clear_on_start", 32'(err), 0);
    endtask

    // Wait (bounded) for done, then compare everything the monitor collected against expectations.
    task automatic finish_block(input int exp_cyc, input bit exp_err, input bit pulse_mid);
        int  n = 0;
        bit  pulsed = 0;
        while (done_cnt == 0 && n < 4000) begin
            @(negedge aclk);
            n++;
            if (pulse_mid && !pulsed && wr_cnt == 5) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        repeat (3) @(negedge aclk);
        start = 1'b0;
        #2;
        chk("done_within_budget", 32'(n < 4000), 1);
        chk("done_pulse_count", 32'(done_cnt), 1);
        if (exp_cyc >= 0) chk("fetch_to_done_cycles", 32'(done_cyc - fetch_cyc), 32'(exp_cyc));
        chk("write_count", 32'(wr_cnt), 16);
        chk("write_order_errors", 32'(order_err), 0);
        chk("write_data_errors", 32'(data_err), 0);
        chk("tlast_placement_errors", 32'(pkt_err), 0);
        chk("tvalid_drop_errors", 32'(vld_drop), 0);
        chk("err_sticky", 32'(err), 32'(exp_err));
        chk("err_rise_next_cycle", 32'(err_rise), 32'(exp_err));
        chk("busy_idle", 32'(busy), 0);
        for (int a = 0; a < 16; a++) chk($sformatf("result_%0d", a), 32'(res[a]), 32'(refm[a]));
    endtask

    vec_t vecs[4];
    vec_t v_full;

    initial begin
        int n;
        vecs[0] = '{100, 100, 0, -1, 1, 96, 0};
        vecs[1] = '{100, 100, 0, 6, 0, 96, 1};
        vecs[2] = '{50, 30, 0, -1, 0, -1, 0};
        vecs[3] = '{100, 100, 20, -1, 0, 416, 0};
        v_full  = '{100, 100, 0, -1, 0, 96, 0};
        for (int a = 0; a < 64; a++) begin
            amem[a] = '0;
            bmem[a] = '0;
        end
        areset = 1'b1;
        start  = 1'b0;
        repeat (3) @(negedge aclk);
        #2;
        check_zero("reset");
        @(negedge aclk);
        areset = 1'b0;

        for (int t = 0; t < 4; t++) begin
            begin_block(vecs[t]);
            finish_block(vecs[t].exp_cycles, vecs[t].exp_err, 1'b0);
        end

        // A accepts beat 0 while B is held off: A's tvalid must drop and addresses hold at k=0.
        manual = 1'b1;
        man_a  = 1'b1;
        man_b  = 1'b0;
        begin_block('{100, 100, 0, -1, 0, 102, 0});
        @(negedge aclk);
        #2;
        chk("skew_a_tvalid_first", 32'(m_axis_a_tvalid), 1);
        for (int s = 0; s < 5; s++) begin
            @(negedge aclk);
            #2;
            chk("skew_a_tvalid_low", 32'(m_axis_a_tvalid), 0);
            chk("skew_b_tvalid_high", 32'(m_axis_b_tvalid), 1);
            chk("skew_a_addr_hold", 32'(a_addr), 0);
            chk("skew_b_addr_hold", 32'(b_addr), 0);
            chk("skew_b_tdata_hold", 32'(m_axis_b_tdata), 32'(bmem[0]));
        end
        man_b = 1'b1;
        @(negedge aclk);
        #2;
        chk("skew_a_addr_next", 32'(a_addr), 1);
        chk("skew_b_addr_next", 32'(b_addr), 4);
        @(negedge aclk);
        #2;
        chk("skew_beat1_a_tvalid", 32'(m_axis_a_tvalid), 1);
        chk("skew_beat1_a_tdata", 32'(m_axis_a_tdata), 32'(amem[1]));
        chk("skew_beat1_b_tdata", 32'(m_axis_b_tdata), 32'(bmem[4]));
        manual = 1'b0;
        finish_block(102, 1'b0, 1'b1);

        // Reset in the middle of element (2,1) beat 2, then a clean recompute.
        begin_block(v_full);
        n = 0;
        while (!(wr_cnt == 9 && qa.size() == 3 && m_axis_a_tvalid) && n < 2000) begin
            @(negedge aclk);
            #2;
            n++;
        end
        chk("mid_reset_reached", 32'(n < 2000), 1);
        areset = 1'b1;
        @(negedge aclk);
        #2;
        check_zero("mid_reset");
        areset = 1'b0;
        begin_block(v_full);
        finish_block(96, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
